// File: rtl/st_byte_to_word_packer_if.sv
// Avalon-ST signal bundle for the byte-to-word packer: 8-bit sink side, 32-bit source side.
// Error pass-through signals exist only when PACKER_ERROR_PASS_EN is defined.
interface st_byte_to_word_packer_if #(
    parameter int SYMBOL_WIDTH = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [SYMBOL_WIDTH-1:0]   in_data;
    logic                      in_startofpacket;
    logic                      in_endofpacket;
    logic                      out_valid;
    logic                      out_ready;
    logic [4*SYMBOL_WIDTH-1:0] out_data;
    logic                      out_startofpacket;
    logic                      out_endofpacket;
    logic [1:0]                out_empty;
`ifdef PACKER_ERROR_PASS_EN
    logic                      in_error;
    logic                      out_error;
`endif

    // slave: the packer's view; master: the surrounding datapath's view
    modport slave (
        input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
`ifdef PACKER_ERROR_PASS_EN
        input  in_error,
        output out_error,
`endif
        output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_empty
    );

    modport master (
        output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
`ifdef PACKER_ERROR_PASS_EN
        output in_error,
        input  out_error,
`endif
        input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_empty
    );
endinterface

// File: rtl/st_byte_to_word_packer.sv
// Avalon-ST 8-to-32 bit big-endian packer preserving sop/eop and generating empty on the last beat.
// Optional error pass-through (OR of all symbol errors per beat) enabled by PACKER_ERROR_PASS_EN.
module st_byte_to_word_packer #(
    parameter int SYMBOL_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    st_byte_to_word_packer_if.slave   st
);
    localparam int SW    = SYMBOL_WIDTH;
    localparam int OUT_W = 4 * SYMBOL_WIDTH;

    if (SYMBOL_WIDTH != 8) begin : g_width_check
        $error("st_byte_to_word_packer: SYMBOL_WIDTH must be 8");
    end

    logic [1:0]       idx;
    logic [1:0]       eff_idx;
    logic [SW-1:0]    acc0, acc1, acc2;
    logic             sop_reg;
    logic             accept;
    logic             complete;
    logic [OUT_W-1:0] word;
    logic [1:0]       empty_nxt;

    assign st.in_ready = ~reset & (st.out_ready | ~st.out_valid);
    assign accept      = st.in_valid & st.in_ready;
    // A sop always opens a fresh word; any partial bytes before it are abandoned.
    assign eff_idx     = st.in_startofpacket ? 2'd0 : idx;
    assign complete    = accept & ((eff_idx == 2'd3) | st.in_endofpacket);
    assign empty_nxt   = st.in_endofpacket ? (2'd3 - eff_idx) : 2'd0;

    always_comb begin
        word = '0;
        case (eff_idx)
            2'd0:    word = {st.in_data, {(3*SW){1'b0}}};
            2'd1:    word = {acc0, st.in_data, {(2*SW){1'b0}}};
            2'd2:    word = {acc0, acc1, st.in_data, {SW{1'b0}}};
            default: word = {acc0, acc1, acc2, st.in_data};
        endcase
    end

`ifdef PACKER_ERROR_PASS_EN
    logic err_acc;
    logic err_word;

    assign err_word = ((eff_idx == 2'd0) ? 1'b0 : err_acc) | st.in_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_acc      <= 1'b0;
            st.out_error <= 1'b0;
        end else if (accept) begin
            err_acc <= complete ? 1'b0 : err_word;
            if (complete) begin
                st.out_error <= err_word;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            idx                  <= 2'd0;
            acc0                 <= '0;
            acc1                 <= '0;
            acc2                 <= '0;
            sop_reg              <= 1'b0;
            st.out_valid         <= 1'b0;
            st.out_data          <= '0;
            st.out_startofpacket <= 1'b0;
            st.out_endofpacket   <= 1'b0;
            st.out_empty         <= 2'd0;
        end else begin
            if (accept) begin
                if (complete) begin
                    idx <= 2'd0;
                end else begin
                    case (eff_idx)
                        2'd0: begin
                            acc0    <= st.in_data;
                            sop_reg <= st.in_startofpacket;
                        end
                        2'd1:    acc1 <= st.in_data;
                        2'd2:    acc2 <= st.in_data;
                        default: ;
                    endcase
                    idx <= eff_idx + 2'd1;
                end
            end

            // Completion only happens when in_ready, so the output register is free to reload.
            if (complete) begin
                st.out_valid         <= 1'b1;
                st.out_data          <= word;
                st.out_startofpacket <= (eff_idx == 2'd0) ? st.in_startofpacket : sop_reg;
                st.out_endofpacket   <= st.in_endofpacket;
                st.out_empty         <= empty_nxt;
            end else if (st.out_ready | ~st.out_valid) begin
                st.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_st_byte_to_word_packer.sv
// Scoreboard bench for st_byte_to_word_packer: packet-level reference model chunks symbols into beats.
module tb_st_byte_to_word_packer;
    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    st_byte_to_word_packer_if #(.SYMBOL_WIDTH(8)) bus ();

    st_byte_to_word_packer #(.SYMBOL_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .st    (bus.slave)
    );

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    bit          rst_q = 1'b0;
    bit          stalled = 1'b0;
    logic [31:0] held = '0;

    task automatic check(input bit ok, input string name, input string info);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, info);
        end
    endtask

    // A packet of n symbols becomes ceil(n/4) beats; a fragment cut by a later sop keeps only full words.
    function automatic void model_push(input logic [7:0] syms[$], input bit full_pkt);
        int    n;
        int    len;
        beat_t b;
        n = syms.size();
        for (int base = 0; base < n; base += 4) begin
            len = (n - base >= 4) ? 4 : n - base;
            if (!full_pkt && len < 4) break;
            b.data = '0;
            for (int j = 0; j < len; j++) b.data[31-8*j -: 8] = syms[base+j];
            b.sop   = (base == 0);
            b.eop   = full_pkt && (base + len == n);
            b.empty = b.eop ? 2'(4 - len) : 2'd0;
            exp_q.push_back(b);
        end
    endfunction

    task automatic send_sym(input logic [7:0] d, input bit s, input bit e);
        int budget;
        bit acc;
        budget = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_startofpacket = s;
        bus.in_endofpacket = e;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (!acc && budget >= 500) begin
                check(1'b0, "in_ready_timeout", $sformatf("symbol %h never accepted, in_ready=%b", d, bus.in_ready));
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_startofpacket = 1'b0;
        bus.in_endofpacket = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] syms[$], input bit full_pkt, input int max_gap);
        int n;
        n = syms.size();
        model_push(syms, full_pkt);
        for (int i = 0; i < n; i++) begin
            send_sym(syms[i], i == 0, full_pkt && (i == n - 1));
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        rdy_mode = 0;
        while (exp_q.size() != 0 && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check(exp_q.size() == 0, "drain", $sformatf("%0d expected beats never appeared, required 0", exp_q.size()));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    always @(posedge clk) rst_q = reset;

    always @(negedge clk) begin
        beat_t e;
        if (reset) check(bus.in_ready == 1'b0, "in_ready_reset", $sformatf("in_ready=%b required 0", bus.in_ready));
        if (rst_q) begin
            check(bus.out_valid === 1'b0 && bus.out_data === 32'h0 && bus.out_startofpacket === 1'b0 &&
                  bus.out_endofpacket === 1'b0 && bus.out_empty === 2'd0, "reset_outputs",
                  $sformatf("valid=%b data=%h sop=%b eop=%b empty=%0d required all 0", bus.out_valid,
                            bus.out_data, bus.out_startofpacket, bus.out_endofpacket, bus.out_empty));
            stalled = 1'b0;
        end else if (!reset) begin
            check(bus.in_ready === (bus.out_ready | ~bus.out_valid), "in_ready_rule",
                  $sformatf("in_ready=%b required %b", bus.in_ready, bus.out_ready | ~bus.out_valid));
            if (stalled)
                check(bus.out_valid === 1'b1 && bus.out_data === held, "stall_hold",
                      $sformatf("valid=%b data=%h required 1 %h", bus.out_valid, bus.out_data, held));
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_beat", $sformatf("data=%h with no beat expected", bus.out_data));
                end else begin
                    e = exp_q.pop_front();
                    check(bus.out_data === e.data && bus.out_startofpacket === e.sop &&
                          bus.out_endofpacket === e.eop && bus.out_empty === e.empty, "beat",
                          $sformatf("got %h sop=%b eop=%b empty=%0d, required %h sop=%b eop=%b empty=%0d",
                                    bus.out_data, bus.out_startofpacket, bus.out_endofpacket, bus.out_empty,
                                    e.data, e.sop, e.eop, e.empty));
                end
            end
            stalled = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            held = bus.out_data;
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int         len;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_startofpacket = 1'b0;
        bus.in_endofpacket = 1'b0;
        bus.out_ready = 1'b1;
`ifdef PACKER_ERROR_PASS_EN
        bus.in_error = 1'b0;
`endif
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        q = {8'h11, 8'h22, 8'h33, 8'h44};
        send_seq(q, 1'b1, 0);
        check(bus.out_valid === 1'b1 && bus.out_data === 32'h11223344, "full_word_latency",
              $sformatf("valid=%b data=%h required 1 11223344", bus.out_valid, bus.out_data));
        drain();

        q = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        send_seq(q, 1'b1, 0);
        drain();

        q = {8'h7F};
        send_seq(q, 1'b1, 0);
        drain();

        q = {8'h01, 8'h02};
        send_seq(q, 1'b0, 0);
        q = {8'h03, 8'h04, 8'h05, 8'h06};
        send_seq(q, 1'b1, 0);
        drain();

        rdy_mode = 2;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        q = {8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9};
        fork
            send_seq(q, 1'b1, 0);
            begin
                repeat (9) begin
                    @(posedge clk);
                    #1;
                end
                rdy_mode = 0;
            end
        join
        drain();

        send_sym(8'hDE, 1'b1, 1'b0);
        send_sym(8'hAD, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
        send_seq(q, 1'b1, 0);
        drain();

        rdy_mode = 1;
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 5) == 0) begin
                q.delete();
                len = $urandom_range(1, 6);
                for (int k = 0; k < len; k++) q.push_back(8'($urandom_range(0, 255)));
                send_seq(q, 1'b0, 2);
            end
            q.delete();
            len = $urandom_range(1, 11);
            for (int k = 0; k < len; k++) q.push_back(8'($urandom_range(0, 255)));
            send_seq(q, 1'b1, 2);
            if (p % 4 == 0) rdy_mode = $urandom_range(1, 2) == 1 ? 1 : 0;
            else rdy_mode = 1;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
